expr_checker_param: RTL and testbench

//  Streaming syntax checker for arithmetic expressions: one ASCII char per accepted cycle.

---
 rtl/expr_checker_param.sv | 126 ++++++++++++
 tb/tb_expr_checker_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_checker_param.sv
// Streaming syntax checker for arithmetic expressions, one ASCII char per enabled cycle.
// Handles multi-digit numbers of bounded length, optional '-' and '/' operators and
// parentheses nested up to a bounded depth. Errors are sticky until clr.
module expr_checker_param #(
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned MAX_DEPTH  = 4,
    parameter bit          ALLOW_SUB  = 1'b1,
    parameter bit          ALLOW_DIV  = 1'b0,
    localparam int unsigned DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    input  logic [7:0]    in,
    output logic          out,
    output logic          err,
    output logic [DW-1:0] depth
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StNum     = 3'd1,
        StOpnd    = 3'd2,
        StClose   = 3'd3,
        StInvalid = 3'd4
    } state_e;

    localparam logic [3:0]    MaxCnt = 4'(MAX_DIGITS);
    localparam logic [DW-1:0] MaxDep = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] OneDep = DW'(1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] depth_d;
    logic          out_d, err_d;
    logic          is_dig, is_op, is_l, is_r, is_nul;

    // Character classification; disallowed operators fall through to "other".
    always_comb begin
        is_dig = (in >= 8'h30) && (in <= 8'h39);
        is_op  = (in == 8'h2b) || (in == 8'h2a) ||
                 (ALLOW_SUB && (in == 8'h2d)) || (ALLOW_DIV && (in == 8'h2f));
        is_l   = (in == 8'h28);
        is_r   = (in == 8'h29);
        is_nul = (in == 8'h00);
    end

    // Next-state: any unlisted transition goes INVALID with depth/cnt left frozen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        depth_d = depth;
        if (en) begin
            unique case (state_q)
                StIdle, StOpnd: begin
                    if (is_dig) begin
                        state_d = StNum;
                        cnt_d   = 4'd1;
                    end else if (is_l && depth != MaxDep) begin
                        state_d = StOpnd;
                        depth_d = depth + OneDep;
                        cnt_d   = 4'd0;
                    end else if (!(is_nul && state_q == StIdle)) begin
                        state_d = StInvalid;
                    end
                end
                StNum: begin
                    if (is_dig && cnt_q < MaxCnt) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (is_op) begin
                        state_d = StOpnd;
                        cnt_d   = 4'd0;
                    end else if (is_r && depth != '0) begin
                        state_d = StClose;
                        depth_d = depth - OneDep;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = StInvalid;
                    end
                end
                StClose: begin
                    if (is_op) begin
                        state_d = StOpnd;
                        cnt_d   = 4'd0;
                    end else if (is_r && depth != '0) begin
                        depth_d = depth - OneDep;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = StInvalid;
                    end
                end
                StInvalid: state_d = StInvalid;
                default: begin
                    // Unreachable encodings recover to a clean idle.
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                    depth_d = '0;
                end
            endcase
        end
    end

    // Moore outputs computed from the next state so they are registered alongside it.
    always_comb begin
        out_d = ((state_d == StNum) || (state_d == StClose)) && (depth_d == '0);
        err_d = (state_d == StInvalid);
    end

    // State, counters and registered outputs; clr aborts asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            depth   <= '0;
            out     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            depth   <= depth_d;
            out     <= out_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_expr_checker_param.sv
// Bench for expr_checker_param: two instances (defaults, and a narrow variant with
// MAX_DIGITS=2, MAX_DEPTH=2, no '-', with '/') driven by the same character stream.
module tb_expr_checker_param;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] ch  = 8'h00;
    logic       o0, e0, o1, e1;
    logic [2:0] d0;
    logic [1:0] d1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    expr_checker_param dut0 (
        .clk(clk), .clr(clr), .en(en), .in(ch), .out(o0), .err(e0), .depth(d0)
    );

    expr_checker_param #(
        .MAX_DIGITS(2), .MAX_DEPTH(2), .ALLOW_SUB(1'b0), .ALLOW_DIV(1'b1)
    ) dut1 (
        .clk(clk), .clr(clr), .en(en), .in(ch), .out(o1), .err(e1), .depth(d1)
    );

    // Reference: remembers the class of the last accepted char, digit run and depth.
    // last: 0 nothing yet, 1 digit, 2 operator, 3 '(', 4 ')'
    typedef struct {
        bit err;
        int depth;
        int run;
        int last;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t step(mdl_t m, logic [7:0] c, int maxdig, int maxdep,
                                  bit sub, bit dv);
        mdl_t r = m;
        bit dig = (c >= "0") && (c <= "9");
        bit op  = (c == "+") || (c == "*") || (sub && c == "-") || (dv && c == "/");
        bit operand_ok = (r.last == 0) || (r.last == 2) || (r.last == 3);
        bit after_val  = (r.last == 1) || (r.last == 4);
        if (r.err) return r;
        if (c == 8'h00) begin
            if (r.last != 0) r.err = 1;
        end else if (dig) begin
            if (operand_ok) begin r.run = 1; r.last = 1; end
            else if (r.last == 1 && r.run < maxdig) r.run++;
            else r.err = 1;
        end else if (op) begin
            if (after_val) begin r.run = 0; r.last = 2; end
            else r.err = 1;
        end else if (c == "(") begin
            if (operand_ok && r.depth < maxdep) begin r.depth++; r.run = 0; r.last = 3; end
            else r.err = 1;
        end else if (c == ")") begin
            if (after_val && r.depth > 0) begin r.depth--; r.run = 0; r.last = 4; end
            else r.err = 1;
        end else begin
            r.err = 1;
        end
        return r;
    endfunction

    function automatic int mout(mdl_t m);
        return (!m.err && (m.last == 1 || m.last == 4) && m.depth == 0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic check_models(input string tag);
        check({tag, ".m0_out"}, int'(o0), mout(m0));
        check({tag, ".m0_err"}, int'(e0), int'(m0.err));
        check({tag, ".m0_depth"}, int'(d0), m0.depth);
        check({tag, ".m1_out"}, int'(o1), mout(m1));
        check({tag, ".m1_err"}, int'(e1), int'(m1.err));
        check({tag, ".m1_depth"}, int'(d1), m1.depth);
    endtask

    task automatic models_reset();
        m0 = '{default: 0};
        m1 = '{default: 0};
    endtask

    task automatic do_reset();
        @(negedge clk);
        en  = 1'b0;
        clr = 1'b1;
        #2 clr = 1'b0;
        models_reset();
    endtask

    task automatic apply(input string tag, input logic [7:0] c, input bit e);
        @(negedge clk);
        ch = c;
        en = e;
        @(posedge clk);
        #1;
        if (e) begin
            m0 = step(m0, c, 4, 4, 1'b1, 1'b0);
            m1 = step(m1, c, 2, 2, 1'b0, 1'b1);
        end
        check_models(tag);
    endtask

    // Async clear asserted between edges must zero every output at once.
    task automatic clr_mid(input string tag);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check({tag, ".clr_out"}, int'(o0), 0);
        check({tag, ".clr_err"}, int'(e0), 0);
        check({tag, ".clr_depth"}, int'(d0), 0);
        check({tag, ".clr_depth1"}, int'(d1), 0);
        @(negedge clk);
        clr = 1'b0;
        models_reset();
    endtask

    typedef struct {
        logic [7:0] c;
        bit         fresh;
        bit         sel;
        bit         eo;
        bit         ee;
        int         ed;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] c, input bit fresh, input bit sel,
                       input bit eo, input bit ee, input int ed);
        vec_t v;
        v.c = c; v.fresh = fresh; v.sel = sel; v.eo = eo; v.ee = ee; v.ed = ed;
        tbl.push_back(v);
    endtask

    initial begin
        string pool = "0123456789+-*/()((";
        models_reset();
        #3;
        check("reset_out", int'(o0), 0);
        check("reset_err", int'(e0), 0);
        check("reset_depth", int'(d0), 0);
        #10 clr = 1'b0;

        // T1 "12+3" on defaults
        add("1", 1, 0, 1, 0, 0); add("2", 0, 0, 1, 0, 0);
        add("+", 0, 0, 0, 0, 0); add("3", 0, 0, 1, 0, 0);
        // T2 "(1+2)*30"
        add("(", 1, 0, 0, 0, 1); add("1", 0, 0, 0, 0, 1);
        add("+", 0, 0, 0, 0, 1); add("2", 0, 0, 0, 0, 1);
        add(")", 0, 0, 1, 0, 0); add("*", 0, 0, 0, 0, 0);
        add("3", 0, 0, 1, 0, 0); add("0", 0, 0, 1, 0, 0);
        // T3 "(((1" with depth bound 2: overflow freezes depth at 2
        add("(", 1, 1, 0, 0, 1); add("(", 0, 1, 0, 0, 2);
        add("(", 0, 1, 0, 1, 2); add("1", 0, 1, 0, 1, 2);
        // T4 "123" with two-digit bound, "1)" unbalanced, "1-2" with '-'
        add("1", 1, 1, 1, 0, 0); add("2", 0, 1, 1, 0, 0); add("3", 0, 1, 0, 1, 0);
        add("1", 1, 0, 1, 0, 0); add(")", 0, 0, 0, 1, 0);
        add("1", 1, 0, 1, 0, 0); add("-", 0, 0, 0, 0, 0); add("2", 0, 0, 1, 0, 0);
        // T5 "5-" with '-' disallowed, "8/2" with '/' allowed
        add("5", 1, 1, 1, 0, 0); add("-", 0, 1, 0, 1, 0);
        add("8", 1, 1, 1, 0, 0); add("/", 0, 1, 0, 0, 0); add("2", 0, 1, 1, 0, 0);
        // NUL idles only in IDLE; "()" is illegal with depth frozen at 1
        add(8'h00, 1, 0, 0, 0, 0); add("1", 0, 0, 1, 0, 0); add(8'h00, 0, 0, 0, 1, 0);
        add("(", 1, 0, 0, 0, 1); add(")", 0, 0, 0, 1, 1);
        // Leading operator and operator-operator
        add("+", 1, 0, 0, 1, 0);
        add("4", 1, 0, 1, 0, 0); add("*", 0, 0, 0, 0, 0); add("+", 0, 0, 0, 1, 0);

        foreach (tbl[i]) begin
            string tag = $sformatf("tbl%0d", i);
            if (tbl[i].fresh) do_reset();
            apply(tag, tbl[i].c, 1'b1);
            if (tbl[i].sel) begin
                check({tag, ".out"}, int'(o1), int'(tbl[i].eo));
                check({tag, ".err"}, int'(e1), int'(tbl[i].ee));
                check({tag, ".depth"}, int'(d1), tbl[i].ed);
            end else begin
                check({tag, ".out"}, int'(o0), int'(tbl[i].eo));
                check({tag, ".err"}, int'(e0), int'(tbl[i].ee));
                check({tag, ".depth"}, int'(d0), tbl[i].ed);
            end
        end

        // en=0 must not consume: after "3+" held chars are ignored, so '+' errors
        do_reset();
        apply("hold", "3", 1'b1);
        apply("hold", "+", 1'b1);
        repeat (3) begin
            apply("hold", "9", 1'b0);
            check("hold.out", int'(o0), 0);
        end
        apply("hold", "+", 1'b1);
        check("hold.plus_err", int'(e0), 1);

        // T6 "3+", hold, async clear mid-cycle, then "7"
        do_reset();
        apply("t6", "3", 1'b1);
        apply("t6", "+", 1'b1);
        repeat (3) apply("t6", "9", 1'b0);
        clr_mid("t6");
        apply("t6", "7", 1'b1);
        check("t6.out7", int'(o0), 1);

        // Clear from a nested, a complete and an errored expression
        do_reset();
        apply("c1", "(", 1'b1);
        apply("c1", "1", 1'b1);
        clr_mid("c1");
        apply("c2", "5", 1'b1);
        clr_mid("c2");
        apply("c3", "+", 1'b1);
        clr_mid("c3");
        apply("c3", "6", 1'b1);

        // Random streams against the reference
        for (int s = 0; s < 40; s++) begin
            int n = $urandom_range(1, 16);
            do_reset();
            for (int k = 0; k < n; k++) begin
                logic [7:0] c;
                int r = $urandom_range(0, 19);
                if (r == 18) c = 8'h00;
                else if (r == 19) c = "x";
                else c = pool[r % pool.len()];
                apply($sformatf("rnd%0d_%0d", s, k), c, ($urandom_range(0, 3) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
